shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for the 8-bit shifter datapath. The shifter stage moves
//  0-3 bit positions per pass (2-bit shamt). This block breaks a shift of 0..7
//  into passes of at most 3, applies them over successive cycles on a working
//  register, and returns the result with a start/done handshake.
//  Supported ops: LSL, LSR, ASR, ROR, ROL.
// PARAMETERS
//  WIDTH    8  data width (fixed at 8 for this shifter)
//  SHAMT_W  3  total shift-amount width; range 0..7
//  STEP_MAX 3  maximum shift per pass (set by the 2-bit stage shamt)
// PORTS
//  clk      in   1        rising-edge clock; the only clock
//  reset_n  in   1        synchronous, active-low reset
//  start    in   1        request; sampled only in IDLE
//  op       in   3        000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, others = pass
//  shamt    in   SHAMT_W  total shift amount
//  d_in     in   WIDTH    operand; captured with start
//  d_out    out  WIDTH    result register; holds last result until next completion
//  busy     out  1        high whenever state != IDLE
//  done     out  1        one-cycle pulse; d_out is valid in that cycle
// BEHAVIOUR
//  Reset: state=IDLE, work=0, remain=0, op_r=0, d_out=0, busy=0, done=0.
//   Reset wins over every other event, including mid-operation.
//  States: IDLE, SHIFT, DONE. All outputs are registered.
//  IDLE: on an edge with start=1, capture work<=d_in, op_r<=op, remain<=shamt.
//   -> SHIFT if shamt!=0 and op is valid.
//   -> DONE if shamt==0 or op is reserved (101/110/111); work passes unchanged.
//  SHIFT: step = min(remain, STEP_MAX). work <= f(op_r, work, step).
//   remain <= remain - step. -> DONE when remain - step == 0, else stay in SHIFT.
//  DONE: d_out <= work on entry; done=1 for exactly this cycle. -> IDLE next edge.
//  Pass functions for step s (0..3):
//   LSL: work << s, zero fill.
//   LSR: work >> s, zero fill.
//   ASR: >> s, filled with work[7].
//   ROR / ROL: rotate by s within 8 bits.
//  Latency: start edge E0; k = ceil(shamt/3) SHIFT cycles; done is high during
//   the cycle after edge E0+k+1. k=0 gives done after E1.
//   Worst case (shamt=7) is 3 SHIFT cycles.
//  start while busy (SHIFT or DONE) is ignored and not queued.
//   The inputs op, shamt and d_in may change freely after capture.
//  start held high continuously: a new operation is captured on the IDLE edge
//   that follows each DONE.
//  d_out does not change during SHIFT; intermediate values are never visible.
//  A reserved op completes like shamt=0: d_out=d_in, done after 1 cycle.
// TESTING
//  1. LSR d_in=8'hB4 shamt=5: passes 3,2; d_out=8'h05; done after E3; busy E1..E3.
//  2. ASR d_in=8'h90 shamt=7: passes 3,3,1; d_out=8'hFF; done after E4.
//     LSL 8'h01 shamt=7 -> 8'h80.
//  3. ROR 8'h81 shamt=1 -> 8'hC0 (done after E2).
//     ROL 8'h81 shamt=4 -> 8'h18 (passes 3,1; done after E3).
//  4. LSL 8'h5A shamt=0 -> d_out=8'h5A, done after E1.
//     op=3'b111, d_in=8'h3C, shamt=6 -> 8'h3C, done after E1.
//  5. Pulse start with new operands during SHIFT of test 1 -> ignored; d_out=8'h05.
//     Then drive reset_n=0 in the 2nd SHIFT cycle of test 2 -> next edge:
//     IDLE, d_out=0, busy=0, no done pulse.
//  6. start held high with shamt=3 back-to-back -> done pulses every 3 cycles;
//     each pulse is one cycle wide; an ASR of 8'h80 by 3 yields 8'hF0.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle between a shift requester and shift_sequencer.
// The master issues start/op/shamt/d_in and the slave returns d_out/busy/done.
interface shift_sequencer_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) ();
    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   d_in;
    logic [WIDTH-1:0]   d_out;
    logic               busy;
    logic               done;

    modport master (
        output start, op, shamt, d_in,
        input  d_out, busy, done
    );

    modport slave (
        input  start, op, shamt, d_in,
        output d_out, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: splits a 0..7 shift into passes of at most
// STEP_MAX positions on a working register, with a start/done handshake.
module shift_sequencer #(
    parameter int WIDTH    = 8,
    parameter int SHAMT_W  = 3,
    parameter int STEP_MAX = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    shift_sequencer_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    localparam logic [SHAMT_W-1:0] STEP_LIM = SHAMT_W'(STEP_MAX);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [SHAMT_W-1:0] remain_q, remain_d;
    logic [2:0]         op_q,     op_d;
    logic [WIDTH-1:0]   d_out_q,  d_out_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [SHAMT_W-1:0] step;
    logic [SHAMT_W-1:0] remain_next;

    function automatic logic [WIDTH-1:0] pass_fn(
        input logic [2:0]         f_op,
        input logic [WIDTH-1:0]   w,
        input logic [SHAMT_W-1:0] s
    );
        logic [2*WIDTH-1:0] ext;
        logic [WIDTH-1:0]   res;
        res = w;
        ext = '0;
        case (f_op)
            OP_LSL: res = w << s;
            OP_LSR: res = w >> s;
            OP_ASR: begin
                ext = {{WIDTH{w[WIDTH-1]}}, w} >> s;
                res = ext[WIDTH-1:0];
            end
            OP_ROR: begin
                ext = {w, w} >> s;
                res = ext[WIDTH-1:0];
            end
            OP_ROL: begin
                ext = {w, w} << s;
                res = ext[2*WIDTH-1:WIDTH];
            end
            default: res = w;
        endcase
        return res;
    endfunction

    always_comb begin
        step        = (remain_q > STEP_LIM) ? STEP_LIM : remain_q;
        remain_next = remain_q - step;

        state_d  = state_q;
        work_d   = work_q;
        remain_d = remain_q;
        op_d     = op_q;
        d_out_d  = d_out_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d   = bus.d_in;
                    op_d     = bus.op;
                    remain_d = bus.shamt;
                    // Zero shift and reserved ops skip SHIFT and pass the operand through.
                    state_d  = (bus.shamt != '0 && bus.op <= OP_ROL) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_d   = pass_fn(op_q, work_q, step);
                remain_d = remain_next;
                if (remain_next == '0) state_d = DONE;
            end
            DONE: begin
                // Result register and done pulse update together on the way back to IDLE.
                d_out_d = work_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            remain_q <= '0;
            op_q     <= '0;
            d_out_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            remain_q <= remain_d;
            op_q     <= op_d;
            d_out_q  <= d_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.d_out = d_out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
